// File: rtl/rd_pkg.sv
// rd_pkg: opcode constants and immediate extension shared by the register-read stage.
package rd_pkg;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  function automatic logic [63:0] imm_ext(input logic [5:0] op, input logic [15:0] imm, input int xlen);
    logic [63:0] v;
    v = (op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? {48'b0, imm} :
        (op == OP_LUI) ? {{32{imm[15]}}, imm, 16'b0} : {{48{imm[15]}}, imm};
    return (xlen >= 64) ? v : v & ((64'd1 << xlen) - 64'd1);
  endfunction
endpackage

// File: rtl/rd_fwd_mux.sv
// rd_fwd_mux: priority forwarding for one operand; lowest matching source wins, r0 reads zero.
module rd_fwd_mux #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]         addr,
  input  logic [XLEN-1:0]           reg_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic [XLEN-1:0]           data,
  output logic                      pending
);
  always_comb begin
    data = reg_data;
    pending = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (fwd_valid[i] && fwd_addr[i*REG_AW +: REG_AW] == addr) begin
        data = fwd_data[i*XLEN +: XLEN];
        pending = fwd_pending[i];
      end
    if (addr == '0) begin
      data = '0;
      pending = 1'b0;
    end
  end
endmodule

// File: rtl/rd_fwd_stage.sv
// rd_fwd_stage: register-read pipeline stage with operand forwarding, load-use stalls and flush.
module rd_fwd_stage
  import rd_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                opcode,
  input  logic [5:0]                funct,
  input  logic [REG_AW-1:0]         rs,
  input  logic [REG_AW-1:0]         rt,
  input  logic [REG_AW-1:0]         rd,
  input  logic [4:0]                shamt,
  input  logic [15:0]               immediate,
  input  logic [25:0]               target,
  input  logic [31:0]               pc,
  input  logic                      register_write,
  input  logic                      branch,
  input  logic                      mem_read,
  input  logic [XLEN-1:0]           register_1,
  input  logic [XLEN-1:0]           register_2,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  input  logic                      flush,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [5:0]                opcode_o,
  output logic [REG_AW-1:0]         rd_o,
  output logic [4:0]                shamt_o,
  output logic [5:0]                funct_o,
  output logic [25:0]               target_o,
  output logic [31:0]               pc_o,
  output logic                      register_write_o,
  output logic                      branch_o,
  output logic                      mem_read_o,
  output logic [XLEN-1:0]           value_1,
  output logic [XLEN-1:0]           value_2,
  output logic [XLEN-1:0]           value_3,
  output logic                      hazard_stall
);
  logic [XLEN-1:0] data_1, data_2;
  logic pend_1, pend_2, load_use, capture;
  rd_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux_1 (
    .addr(rs), .reg_data(register_1), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .data(data_1), .pending(pend_1)
  );
  rd_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_mux_2 (
    .addr(rt), .reg_data(register_2), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .data(data_2), .pending(pend_2)
  );
  // rd_o != 0 already excludes a zero rs/rt from matching
  assign load_use = out_valid && mem_read_o && rd_o != '0 && (rd_o == rs || rd_o == rt);
  assign hazard_stall = in_valid && (load_use || pend_1 || pend_2);
  assign in_ready = !rst && !flush && !hazard_stall && (!out_valid || out_ready);
  assign capture = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      opcode_o <= '0;
      rd_o <= '0;
      shamt_o <= '0;
      funct_o <= '0;
      target_o <= '0;
      pc_o <= '0;
      register_write_o <= 1'b0;
      branch_o <= 1'b0;
      mem_read_o <= 1'b0;
      value_1 <= '0;
      value_2 <= '0;
      value_3 <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      opcode_o <= opcode;
      rd_o <= rd;
      shamt_o <= shamt;
      funct_o <= funct;
      target_o <= target;
      pc_o <= pc;
      register_write_o <= register_write;
      branch_o <= branch;
      mem_read_o <= mem_read;
      value_1 <= data_1;
      value_2 <= data_2;
      value_3 <= XLEN'(imm_ext(opcode, immediate, XLEN));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rd_fwd_stage.sv
// tb_rd_fwd_stage: directed stimulus with a queue scoreboard checked by an output monitor.
module tb_rd_fwd_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, in_ready, register_write, branch, mem_read, flush, out_ready, out_valid;
  logic [5:0] opcode, funct, opcode_o, funct_o;
  logic [4:0] rs, rt, rd, shamt, rd_o, shamt_o;
  logic [15:0] immediate;
  logic [25:0] target, target_o;
  logic [31:0] pc, pc_o, register_1, register_2, value_1, value_2, value_3;
  logic [1:0] fwd_valid, fwd_pending;
  logic [9:0] fwd_addr;
  logic [63:0] fwd_data;
  logic register_write_o, branch_o, mem_read_o, hazard_stall;

  rd_fwd_stage #(.XLEN(32), .REG_AW(5), .NUM_FWD(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .immediate(immediate), .target(target), .pc(pc),
    .register_write(register_write), .branch(branch), .mem_read(mem_read),
    .register_1(register_1), .register_2(register_2), .fwd_valid(fwd_valid),
    .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .opcode_o(opcode_o), .rd_o(rd_o),
    .shamt_o(shamt_o), .funct_o(funct_o), .target_o(target_o), .pc_o(pc_o),
    .register_write_o(register_write_o), .branch_o(branch_o), .mem_read_o(mem_read_o),
    .value_1(value_1), .value_2(value_2), .value_3(value_3), .hazard_stall(hazard_stall)
  );

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic        mr;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] v1, v2, v3;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output pc_o=%0h required=none", pc_o);
      end else begin
        e = q.pop_front();
        check("pc_o", pc_o, e.pc);
        check("branch_o", 32'(branch_o), 32'(e.br));
        check("mem_read_o", 32'(mem_read_o), 32'(e.mr));
        check("opcode_o", 32'(opcode_o), 32'(e.op));
        check("rd_o", 32'(rd_o), 32'(e.rd));
        check("value_1", value_1, e.v1);
        check("value_2", value_2, e.v2);
        check("value_3", value_3, e.v3);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    in_valid = 0; opcode = 0; funct = 0; rs = 0; rt = 0; rd = 0; shamt = 0; immediate = 0;
    target = 0; pc = 0; register_write = 0; branch = 0; mem_read = 0;
    register_1 = 0; register_2 = 0; fwd_valid = 0; fwd_pending = 0; fwd_addr = 0; fwd_data = 0;
  endtask

  task automatic send(input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] e3, input bit push);
    int n;
    in_valid = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    check("send_accept", 32'(in_ready), 32'd1);
    if (push) q.push_back('{pc, branch, mem_read, opcode, rd, e1, e2, e3});
    tick();
    in_valid = 0;
  endtask

  initial begin
    clear();
    rst = 1; flush = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_value_1", value_1, 0);
    check("rst_value_3", value_3, 0);
    check("rst_pc_o", pc_o, 0);
    check("rst_branch_o", 32'(branch_o), 0);
    tick();
    rst = 0; out_ready = 1;
    // beq
    opcode = 6'h04; rs = 1; rt = 2; immediate = 16'd56; pc = 32'd31; branch = 1;
    register_1 = 4; register_2 = 45;
    send(32'd4, 32'd45, 32'd56, 1);
    clear();
    // both operands forwarded, index 0 wins
    funct = 6'h20; rs = 3; rt = 3; rd = 4; pc = 32'h40; register_1 = 100; register_2 = 200;
    fwd_valid = 2'b11; fwd_addr = {5'd3, 5'd3}; fwd_data = {32'd7, 32'd9};
    send(32'd9, 32'd9, 32'd0, 1);
    clear();
    // r0 never forwards
    funct = 6'h20; rs = 0; rt = 3; pc = 32'h44; register_1 = 77; register_2 = 88;
    fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'd0, 32'd55};
    send(32'd0, 32'd88, 32'd0, 1);
    clear();
    opcode = 6'h0D; immediate = 16'h8001; pc = 32'h48;
    send(32'd0, 32'd0, 32'h0000_8001, 1);
    opcode = 6'h08; pc = 32'h4C;
    send(32'd0, 32'd0, 32'hFFFF_8001, 1);
    opcode = 6'h0F; immediate = 16'h1234; pc = 32'h50;
    send(32'd0, 32'd0, 32'h1234_0000, 1);
    clear();
    // lw r5 then add r6,r5,r1
    opcode = 6'h23; rs = 1; rd = 5; mem_read = 1; register_write = 1; pc = 32'h60;
    immediate = 16'h0008; register_1 = 32'h1000;
    send(32'h1000, 32'd0, 32'd8, 1);
    clear();
    funct = 6'h20; rs = 5; rt = 1; rd = 6; pc = 32'h64; register_1 = 32'hDEAD; register_2 = 32'h11;
    in_valid = 1;
    @(negedge clk);
    check("lu_hazard", 32'(hazard_stall), 1);
    check("lu_in_ready", 32'(in_ready), 0);
    tick();
    fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd5}; fwd_data = {32'd0, 32'h5555};
    @(negedge clk);
    check("lu_bubble", 32'(out_valid), 0);
    check("lu_hazard_gone", 32'(hazard_stall), 0);
    check("lu_in_ready_back", 32'(in_ready), 1);
    q.push_back('{pc, branch, mem_read, opcode, rd, 32'h5555, 32'h11, 32'd0});
    tick();
    clear();
    // pending source stalls for as long as it stays pending
    funct = 6'h20; rs = 7; rt = 2; rd = 8; pc = 32'h70; register_1 = 1; register_2 = 32'h22;
    fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_addr = {5'd0, 5'd7}; fwd_data = {32'd0, 32'h77};
    in_valid = 1;
    repeat (2) begin
      @(negedge clk);
      check("pend_hazard", 32'(hazard_stall), 1);
      check("pend_in_ready", 32'(in_ready), 0);
      tick();
    end
    fwd_pending = 0;
    send(32'h77, 32'h22, 32'd0, 1);
    clear();
    tick();
    tick();
    // backpressure then flush
    out_ready = 0;
    rs = 1; register_1 = 32'hAAAA; pc = 32'h100;
    send(32'hAAAA, 32'd0, 32'd0, 0);
    rs = 1; register_1 = 32'hBBBB; pc = 32'h200;
    in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_pc_o", pc_o, 32'h100);
      check("bp_value_1", value_1, 32'hAAAA);
      tick();
    end
    flush = 1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 0);
    tick();
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 0);
    out_ready = 1;
    tick();
    @(negedge clk);
    check("flush_dropped", 32'(out_valid), 0);
    check("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
